// File: rtl/mips_pkg.sv
// Shared constants for the MIPS pipeline blocks.
//   INSTR_W  : instruction width in bits
//   ADDR_W   : default lane address width (one lane entry per instruction word)
//   RESET_PC : default byte PC loaded on reset (4-aligned)
//   NOP      : all-zero instruction, used as the reset value of instruction registers
package mips_pkg;
    localparam int          INSTR_W  = 32;
    localparam int          ADDR_W   = 9;
    localparam int unsigned RESET_PC = 0;
    localparam logic [INSTR_W-1:0] NOP = 32'h0000_0000;
endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry skid buffer holding an {instruction, pc} pair for the fetch stage.
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   i_flush            : drop the held entry (redirect)
//   i_push             : capture i_push_instr / i_push_pc
//   i_pop              : release the held entry
//   o_valid            : entry held
//   o_instr, o_pc      : held entry contents
module fetch_skid_buf
    import mips_pkg::*;
#(
    parameter int PC_W = ADDR_W + 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_flush,
    input  logic               i_push,
    input  logic [INSTR_W-1:0] i_push_instr,
    input  logic [PC_W-1:0]    i_push_pc,
    input  logic               i_pop,
    output logic               o_valid,
    output logic [INSTR_W-1:0] o_instr,
    output logic [PC_W-1:0]    o_pc
);
    logic               r_valid;
    logic [INSTR_W-1:0] r_instr;
    logic [PC_W-1:0]    r_pc;

    // Push and pop never coincide in the fetch stage (push only happens
    // while the output slot is held); push is given priority regardless.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_instr <= NOP;
            r_pc    <= '0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end else if (i_push) begin
            r_valid <= 1'b1;
            r_instr <= i_push_instr;
            r_pc    <= i_push_pc;
        end else if (i_pop) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_instr = r_instr;
    assign o_pc    = r_pc;
endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, issues one shared read to the four byte-lane
// instruction BRAMs, merges the returned bytes into a 32-bit word and hands it
// to decode. Handles sequential increment, redirects, decode back-pressure and
// lane-valid disagreement.
// Ports:
//   clk, rst                   : clock, synchronous active-high reset
//   redirect_valid/redirect_pc : load a new byte PC (bits [1:0] ignored)
//   mem_rd_en/mem_rd_addr      : shared read strobe and lane address
//   mem_data1..4/mem_valid1..4 : lane bytes (lane 1 = MSB) and valids, 1 cycle after strobe
//   if_valid/if_ready          : decode handshake
//   if_instr/if_pc/if_pc_plus4 : delivered instruction, its byte PC, PC + 4
//   lane_err                   : sticky flag, lane valids disagreed
//
// Handshake: if_valid/if_ready follow strict valid/ready rules -- a transfer
// happens on a rising edge where both are high; while if_valid && !if_ready
// the slot (if_instr, if_pc) is held stable and if_valid stays high unless a
// redirect or reset flushes the stage.
module instruction_fetch
    import mips_pkg::*;
#(
    parameter int          ADDR_W   = mips_pkg::ADDR_W,
    parameter int unsigned RESET_PC = mips_pkg::RESET_PC
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               redirect_valid,
    input  logic [ADDR_W+1:0]  redirect_pc,
    output logic               mem_rd_en,
    output logic [ADDR_W-1:0]  mem_rd_addr,
    input  logic [7:0]         mem_data1,
    input  logic [7:0]         mem_data2,
    input  logic [7:0]         mem_data3,
    input  logic [7:0]         mem_data4,
    input  logic               mem_valid1,
    input  logic               mem_valid2,
    input  logic               mem_valid3,
    input  logic               mem_valid4,
    output logic               if_valid,
    input  logic               if_ready,
    output logic [INSTR_W-1:0] if_instr,
    output logic [ADDR_W+1:0]  if_pc,
    output logic [ADDR_W+1:0]  if_pc_plus4,
    output logic               lane_err
);
    localparam int PC_W = ADDR_W + 2;
    localparam logic [PC_W-1:0] LP_RESET_PC = {RESET_PC[ADDR_W+1:2], 2'b00};
    localparam logic [PC_W-1:0] LP_PC_STEP  = {{(ADDR_W-1){1'b0}}, 3'b100};

    logic [PC_W-1:0]    r_pc;
    logic               r_inflight;
    logic [PC_W-1:0]    r_inflight_pc;
    logic               r_if_valid;
    logic [INSTR_W-1:0] r_if_instr;
    logic [PC_W-1:0]    r_if_pc;
    logic               r_squash;
    logic               r_lane_err;

    logic               w_skid_valid;
    logic [INSTR_W-1:0] w_skid_instr;
    logic [PC_W-1:0]    w_skid_pc;
    logic               w_consume;
    logic               w_slot_free;
    logic               w_all_valid;
    logic               w_any_valid;
    logic               w_ret;
    logic               w_lane_bad;
    logic [INSTR_W-1:0] w_word;
    logic               w_skid_push;
    logic               w_skid_pop;
    logic               w_issue;
    logic               w_unused_pc_lsbs;

    assign w_unused_pc_lsbs = ^redirect_pc[1:0];

    assign w_consume   = r_if_valid && if_ready;
    assign w_slot_free = !r_if_valid || w_consume;
    assign w_all_valid = mem_valid1 && mem_valid2 && mem_valid3 && mem_valid4;
    assign w_any_valid = mem_valid1 || mem_valid2 || mem_valid3 || mem_valid4;
    // r_squash is belt-and-braces: a redirect already clears r_inflight.
    assign w_ret       = r_inflight && !r_squash && w_all_valid;
    assign w_lane_bad  = r_inflight && w_any_valid && !w_all_valid;
    assign w_word      = {mem_data1, mem_data2, mem_data3, mem_data4};

    // Issue is held off while a stalled slot already has a read behind it:
    // that read lands in the skid, and the skid being full blocks further
    // issue, so at most two words are ever buffered.
    assign w_issue = !rst && !redirect_valid && !w_skid_valid
                     && !(r_if_valid && !if_ready && r_inflight);

    // The skid drains into the slot ahead of any new return.
    assign w_skid_pop  = !redirect_valid && w_slot_free && w_skid_valid;
    assign w_skid_push = !redirect_valid && !w_slot_free && w_ret;

    fetch_skid_buf #(
        .PC_W (PC_W)
    ) u_skid (
        .clk          (clk),
        .rst          (rst),
        .i_flush      (redirect_valid),
        .i_push       (w_skid_push),
        .i_push_instr (w_word),
        .i_push_pc    (r_inflight_pc),
        .i_pop        (w_skid_pop),
        .o_valid      (w_skid_valid),
        .o_instr      (w_skid_instr),
        .o_pc         (w_skid_pc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc          <= LP_RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
            r_if_valid    <= 1'b0;
            r_if_instr    <= NOP;
            r_if_pc       <= '0;
            r_squash      <= 1'b0;
            r_lane_err    <= 1'b0;
        end else if (redirect_valid) begin
            r_pc       <= {redirect_pc[ADDR_W+1:2], 2'b00};
            r_inflight <= 1'b0;
            r_if_valid <= 1'b0;
            r_squash   <= 1'b1;
        end else begin
            r_squash <= 1'b0;

            if (w_lane_bad) begin
                // Drop the word and any read issued this cycle (it targets
                // the following PC and would arrive out of order), then
                // re-fetch the failed address.
                r_lane_err <= 1'b1;
                r_inflight <= 1'b0;
                r_pc       <= r_inflight_pc;
            end else begin
                r_inflight <= w_issue;
                if (w_issue) begin
                    r_inflight_pc <= r_pc;
                    r_pc          <= r_pc + LP_PC_STEP;
                end
            end

            if (w_slot_free) begin
                if (w_skid_valid) begin
                    r_if_valid <= 1'b1;
                    r_if_instr <= w_skid_instr;
                    r_if_pc    <= w_skid_pc;
                end else if (w_ret) begin
                    r_if_valid <= 1'b1;
                    r_if_instr <= w_word;
                    r_if_pc    <= r_inflight_pc;
                end else begin
                    r_if_valid <= 1'b0;
                end
            end
        end
    end

    assign mem_rd_en   = w_issue;
    assign mem_rd_addr = r_pc[ADDR_W+1:2];
    assign if_valid    = r_if_valid;
    assign if_instr    = r_if_instr;
    assign if_pc       = r_if_pc;
    assign if_pc_plus4 = r_if_pc + LP_PC_STEP;
    assign lane_err    = r_lane_err;
endmodule
